// File: rtl/replica_pkg.sv
// Shared types for the replica-exchange host write path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package replica_pkg;

    // AXI write response codes seen on the core B channel.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    // Issue FSM: ISSUE drives both channels, WAIT_* drive the half still owed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_AW = 2'd2,
        WAIT_W  = 2'd3
    } wq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is data-only; contents behind the pointers never matter.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axi_wr_queue.sv
// AXI4-Lite write decoupling queue; AW/W buffered independently, replayed as pairs to the core (AXI_WQ_POSTED_EN: local B).
// Latency: a pair whose later half is accepted in cycle N is presented to the core in cycle N+1.
// Backpressure: s_awready/s_wready drop on FIFO full (and on DEPTH pending host B in posted mode); issue stalls at DEPTH outstanding.
module axi_wr_queue
    import replica_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  idle,
    output logic                  bresp_err
);
    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic              aw_full, aw_empty, w_full, w_empty;
    logic              aw_push, w_push, in_gate;
    logic [CW-1:0]     aw_cnt, w_cnt;
    logic [DATA_W+SW-1:0] w_head;
    wq_state_t         state_q;
    logic              m_awvalid_q, m_wvalid_q;
    logic              aw_hs, w_hs, pop_pair, b_dec;
    logic              aw_avail, w_avail, pair_nxt;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;

    assign s_awready = !reset && !aw_full && in_gate;
    assign s_wready  = !reset && !w_full && in_gate;
    assign aw_push   = s_awvalid && s_awready;
    assign w_push    = s_wvalid && s_wready;

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_aw_fifo (
        .clk(clk), .reset(reset), .push(aw_push), .din(s_awaddr), .pop(pop_pair),
        .head(m_awaddr), .full(aw_full), .empty(aw_empty), .count(aw_cnt)
    );

    sync_fifo #(.WIDTH(DATA_W + SW), .DEPTH(DEPTH)) u_w_fifo (
        .clk(clk), .reset(reset), .push(w_push), .din({s_wdata, s_wstrb}), .pop(pop_pair),
        .head(w_head), .full(w_full), .empty(w_empty), .count(w_cnt)
    );

    assign {m_wdata, m_wstrb} = w_head;
    assign m_awvalid = m_awvalid_q;
    assign m_wvalid  = m_wvalid_q;
    assign aw_hs     = m_awvalid_q && m_awready;
    assign w_hs      = m_wvalid_q && m_wready;

    // A pair completes when its last outstanding half handshakes; both heads pop together.
    always_comb begin
        pop_pair = 1'b0;
        case (state_q)
            ISSUE:   pop_pair = aw_hs && w_hs;
            WAIT_W:  pop_pair = w_hs;
            WAIT_AW: pop_pair = aw_hs;
            default: pop_pair = 1'b0;
        endcase
    end

    // Look ahead at next-cycle FIFO occupancy so a fresh pair issues one cycle after acceptance.
    always_comb begin
        aw_avail = pop_pair ? ((aw_cnt > CNT_ONE) || aw_push) : (!aw_empty || aw_push);
        w_avail  = pop_pair ? ((w_cnt > CNT_ONE) || w_push) : (!w_empty || w_push);
    end

    assign b_dec    = m_bvalid && m_bready && (out_cnt_q != '0);
    assign pair_nxt = aw_avail && w_avail && (out_cnt_d < CNT_MAX);

    // Outstanding-write count: +1 per completed pair, -1 per core response.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (pop_pair && !b_dec)      out_cnt_d = out_cnt_q + CNT_ONE;
        else if (!pop_pair && b_dec) out_cnt_d = out_cnt_q - CNT_ONE;
    end

    // Issue FSM with registered channel valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
        end else if (pop_pair || state_q == IDLE) begin
            if (pair_nxt) begin
                state_q     <= ISSUE;
                m_awvalid_q <= 1'b1;
                m_wvalid_q  <= 1'b1;
            end else begin
                state_q     <= IDLE;
                m_awvalid_q <= 1'b0;
                m_wvalid_q  <= 1'b0;
            end
        end else if (state_q == ISSUE && aw_hs) begin
            state_q     <= WAIT_W;
            m_awvalid_q <= 1'b0;
        end else if (state_q == ISSUE && w_hs) begin
            state_q    <= WAIT_AW;
            m_wvalid_q <= 1'b0;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk) begin
        if (reset) out_cnt_q <= '0;
        else       out_cnt_q <= out_cnt_d;
    end

`ifdef AXI_WQ_POSTED_EN
    localparam logic signed [CW+1:0] BAL_ONE = (CW+2)'(1);

    logic [CW-1:0]        bpend_q, bpend_d;
    logic signed [CW+1:0] bal_q, bal_d;
    logic                 pair_formed, b_pop, bresp_err_q;

    assign in_gate   = (bpend_q < CNT_MAX);
    assign s_bvalid  = (bpend_q != '0);
    assign s_bresp   = OKAY;
    assign m_bready  = 1'b1;
    assign bresp_err = bresp_err_q;
    assign b_pop     = s_bvalid && s_bready;
    assign idle      = aw_empty && w_empty && (state_q == IDLE) && (out_cnt_q == '0) && (bpend_q == '0);

    // AW-minus-W balance: a lone push forms a pair only if the other side is already ahead.
    always_comb begin
        bal_d       = bal_q;
        pair_formed = 1'b0;
        if (aw_push && w_push) begin
            pair_formed = 1'b1;
        end else if (aw_push) begin
            pair_formed = bal_q[CW+1];
            bal_d       = bal_q + BAL_ONE;
        end else if (w_push) begin
            pair_formed = !bal_q[CW+1] && (bal_q != '0);
            bal_d       = bal_q - BAL_ONE;
        end
    end

    // Pending host responses: one per formed pair, retired by the host B handshake.
    always_comb begin
        bpend_d = bpend_q;
        if (pair_formed && !b_pop)      bpend_d = bpend_q + CNT_ONE;
        else if (!pair_formed && b_pop) bpend_d = bpend_q - CNT_ONE;
    end

    // Posted-mode state, with a sticky error for any non-OKAY core response.
    always_ff @(posedge clk) begin
        if (reset) begin
            bal_q       <= '0;
            bpend_q     <= '0;
            bresp_err_q <= 1'b0;
        end else begin
            bal_q       <= bal_d;
            bpend_q     <= bpend_d;
            bresp_err_q <= bresp_err_q || (m_bvalid && (m_bresp != OKAY));
        end
    end
`else
    assign in_gate   = 1'b1;
    assign s_bvalid  = m_bvalid;
    assign s_bresp   = m_bresp;
    assign m_bready  = s_bready;
    assign bresp_err = 1'b0;
    assign idle      = aw_empty && w_empty && (state_q == IDLE) && (out_cnt_q == '0);
`endif

endmodule

// File: doc/axi_wr_queue.md
# axi_wr_queue

Write-channel decoupling queue in front of the replica-exchange core's AXI slave port. It accepts host AXI4-Lite writes (seeds, two-point distances, ordering words, run command) on its slave side, independently of AW/W arrival order. It buffers them and replays each address/data pair on its master side into the core's `S_AXI_AW*`/`S_AXI_W*`/`S_AXI_B*` ports. Read channels bypass this block.

## Interface
Parameters:
- `DEPTH`, 4: entries per AW and W FIFO. Power of two, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 64: data width. Strobe width is `DATA_W/8`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `s_awaddr` in `ADDR_W`; `s_awvalid` in 1; `s_awready` out 1: host write address.
- `s_wdata` in `DATA_W`; `s_wstrb` in `DATA_W/8`; `s_wvalid` in 1; `s_wready` out 1: host write data.
- `s_bresp` out 2; `s_bvalid` out 1; `s_bready` in 1: host write response.
- `m_awaddr` out `ADDR_W`; `m_awvalid` out 1; `m_awready` in 1: core write address.
- `m_wdata` out `DATA_W`; `m_wstrb` out `DATA_W/8`; `m_wvalid` out 1; `m_wready` in 1: core write data.
- `m_bresp` in 2; `m_bvalid` in 1; `m_bready` out 1: core write response.
- `idle` out 1: both FIFOs empty, issue FSM in IDLE, and no outstanding or pending responses.
- `bresp_err` out 1: sticky flag, set by a non-OKAY downstream response.

## Operation
- Two independent FIFOs: AW holds `{addr}`, W holds `{data,strb}`.
  - `s_awready = !aw_full`.
  - `s_wready = !w_full`.
  - A push happens on each valid&ready.
  - Full and push-with-pop in the same cycle is not accepted, because ready is derived from full only.
- Issue FSM states:
  - IDLE: when both FIFOs are non-empty and `out_cnt < DEPTH`, go to ISSUE.
  - ISSUE: `m_awvalid` and `m_wvalid` are driven from the FIFO heads.
    - Both handshakes in the same cycle: pop both FIFOs and increment `out_cnt`. If another pair is ready, stay in ISSUE; otherwise go to IDLE.
    - AW handshake only: go to WAIT_W.
    - W handshake only: go to WAIT_AW.
  - WAIT_W: only `m_wvalid` is asserted. On W handshake, pop both FIFOs and apply the same next-state rule as ISSUE.
  - WAIT_AW: only `m_awvalid` is asserted. On AW handshake, pop both FIFOs and apply the same next-state rule as ISSUE.
  - Heads are held stable while their valid is high.
- `out_cnt` range is 0..DEPTH.
  - Increments on pair completion.
  - Decrements on `m_bvalid & m_bready`.
  - Increment and decrement in the same cycle leave it unchanged.
- Response path (macro off): combinational passthrough.
  - `s_bvalid = m_bvalid`, `s_bresp = m_bresp`, `m_bready = s_bready`.
  - `bresp_err` is tied to 0.
- Reset mid-operation: all FIFOs, counters and the FSM clear. Any in-flight pair is dropped, and the host must re-issue it.

## Timing
- Reset values:
  - `s_awready = 0` and `s_wready = 0` while `reset` is high; both are 1 in the first cycle after.
  - `m_awvalid = 0`, `m_wvalid = 0`, `s_bvalid = 0`, `bresp_err = 0`, `idle = 1`.
- Latency: a pair whose later half is accepted in cycle N has `m_awvalid`/`m_wvalid` high in cycle N+1 at the earliest.
- Throughput: one write per cycle when the core holds both readys high.
- AW before W, or W before AW, on the slave side: pairing is strictly FIFO-order.

## Configuration
- `AXI_WQ_POSTED_EN` defined (posted writes):
  - Upstream B is generated locally. `bpend` is incremented once per slave-side pair formed. A pair is formed when an AW and a W are both accepted, in any cycle order, tracked by a signed `aw_count - w_count` balance.
  - `s_bvalid = (bpend != 0)` and `s_bresp = 2'b00`.
  - `m_bready = 1`. `bresp_err` is set on `m_bvalid & m_bresp != 0` and cleared only by reset.
  - `s_awready` and `s_wready` are additionally gated by `bpend < DEPTH`.
- Not defined: passthrough response path, as described under Operation.

## Structure
- In `replica_pkg`: the `axi_resp_t` enum (OKAY=0, SLVERR=2) and the `wq_state_t` enum (IDLE, ISSUE, WAIT_AW, WAIT_W).
- Sub-module `sync_fifo #(WIDTH, DEPTH)`, instantiated twice, with ports push/pop/full/empty/head. Its pointers carry one extra wrap bit.

## Test plan
- Simultaneous AW/W, addr 0x10 and data 0x0123456789ABCDEF, with the core always ready: `m_awvalid` and `m_wvalid` rise one cycle later carrying the same values. `s_bvalid` follows `m_bvalid`.
- Three W beats, then three AW beats, 0x00, 0x08 and 0x10, with data D0/D1/D2: the core sees (0x00,D0), (0x08,D1), (0x10,D2) in order.
- `m_wready` held low for 5 cycles while `m_awready = 1`: FSM reaches WAIT_W, `m_awvalid` drops after 1 cycle, and `m_wdata` is held stable until the handshake.
- Five pairs pushed with `m_awready = 0` and `DEPTH = 4`: `s_awready = 0` after the 4th AW. Releasing `m_awready` drains the FIFO in order.
- `reset` asserted while in WAIT_AW with 2 entries queued: the next cycle shows `idle = 1`, and a subsequent write issues cleanly.
- Posted mode, core returns `m_bresp = 2` on the 2nd write: both host B responses are OKAY, and `bresp_err = 1` from the cycle after and stays set.
